// File: rtl/shared_event_fifo_if.sv
// Handshake and status bundle between the shared event FIFO and its users.
// The master side writes words and pops them; the slave side is the FIFO.
interface shared_event_fifo_if #(
    parameter int WIDTH     = 64,
    parameter int FIFO_BITS = 11
);
    logic [WIDTH-2:0]   data_in;
    logic               write_fifo_n;
    logic               read_fifo_n;
    logic               clear_overflow;
    logic [WIDTH-2:0]   tx_data;
    logic [FIFO_BITS:0] fifo_counter;
    logic               fifo_full;
    logic               fifo_half;
    logic               fifo_empty;
    logic               fifo_overflow;
    logic [15:0]        overflow_count;
    logic [FIFO_BITS:0] fifo_high_water;

    modport master (
        output data_in, write_fifo_n, read_fifo_n, clear_overflow,
        input  tx_data, fifo_counter, fifo_full, fifo_half, fifo_empty,
               fifo_overflow, overflow_count, fifo_high_water
    );

    modport slave (
        input  data_in, write_fifo_n, read_fifo_n, clear_overflow,
        output tx_data, fifo_counter, fifo_full, fifo_half, fifo_empty,
               fifo_overflow, overflow_count, fifo_high_water
    );
endinterface

// File: rtl/shared_event_fifo.sv
// Shared event FIFO: stores event words, drops writes when full and counts drops.
// Optional peak-occupancy tracking is enabled by defining SHARED_FIFO_HIGH_WATER_EN.
module shared_event_fifo #(
    parameter int WIDTH     = 64,
    parameter int FIFO_BITS = 11
) (
    input  logic              clk,
    input  logic              reset_n_clk,
    shared_event_fifo_if.slave bus
);
    localparam int DW = WIDTH - 1;
    localparam int CW = FIFO_BITS + 1;
    localparam int DEPTH = 2 ** FIFO_BITS;
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {FIFO_BITS{1'b0}}};
    localparam logic [CW-1:0] HALF_C  = {2'b01, {(FIFO_BITS-1){1'b0}}};
    localparam logic [FIFO_BITS-1:0] PTR_ONE_C = {{(FIFO_BITS-1){1'b0}}, 1'b1};

    logic [DW-1:0]        mem_r [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_r;
    logic [FIFO_BITS-1:0] rd_ptr_r;
    logic [CW-1:0]        counter_r;
    logic [DW-1:0]        tx_data_r;
    logic                 full_r;
    logic                 half_r;
    logic                 empty_r;
    logic                 overflow_r;
    logic [15:0]          overflow_count_r;

    logic                 wr_acc_s;
    logic                 rd_acc_s;
    logic                 drop_s;
    logic [CW-1:0]        counter_nxt_s;

    // Accept/drop decisions and next occupancy; flags use the registered full/empty state.
    always_comb begin
        wr_acc_s      = 1'b0;
        rd_acc_s      = 1'b0;
        drop_s        = 1'b0;
        counter_nxt_s = counter_r;
        if (!bus.write_fifo_n) begin
            wr_acc_s = ~full_r;
            drop_s   = full_r;
        end else begin
            wr_acc_s = 1'b0;
            drop_s   = 1'b0;
        end
        if (!bus.read_fifo_n) begin
            rd_acc_s = ~empty_r;
        end else begin
            rd_acc_s = 1'b0;
        end
        counter_nxt_s = counter_r + {{(CW-1){1'b0}}, wr_acc_s}
                                  - {{(CW-1){1'b0}}, rd_acc_s};
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.data_in;
        end
    end

    // Pointers, occupancy, registered flags and read data.
    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            wr_ptr_r  <= {FIFO_BITS{1'b0}};
            rd_ptr_r  <= {FIFO_BITS{1'b0}};
            counter_r <= {CW{1'b0}};
            tx_data_r <= {DW{1'b0}};
            full_r    <= 1'b0;
            half_r    <= 1'b0;
            empty_r   <= 1'b1;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_ONE_C;
                tx_data_r <= mem_r[rd_ptr_r];
            end
            counter_r <= counter_nxt_s;
            full_r    <= (counter_nxt_s == DEPTH_C);
            half_r    <= (counter_nxt_s >= HALF_C);
            empty_r   <= (counter_nxt_s == {CW{1'b0}});
        end
    end

    // Sticky overflow flag and saturating drop count; a clear beats a same-cycle drop.
    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            overflow_r       <= 1'b0;
            overflow_count_r <= 16'h0000;
        end else if (bus.clear_overflow) begin
            overflow_r       <= 1'b0;
            overflow_count_r <= 16'h0000;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (overflow_count_r != 16'hFFFF) begin
                overflow_count_r <= overflow_count_r + 16'h0001;
            end
        end
    end

`ifdef SHARED_FIFO_HIGH_WATER_EN
    logic [CW-1:0] high_water_r;

    // Peak occupancy, tracked against the next counter so it moves with fifo_counter.
    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            high_water_r <= {CW{1'b0}};
        end else if (bus.clear_overflow) begin
            high_water_r <= {CW{1'b0}};
        end else if (counter_nxt_s > high_water_r) begin
            high_water_r <= counter_nxt_s;
        end
    end

    assign bus.fifo_high_water = high_water_r;
`else
    assign bus.fifo_high_water = {CW{1'b0}};
`endif

    assign bus.tx_data        = tx_data_r;
    assign bus.fifo_counter   = counter_r;
    assign bus.fifo_full      = full_r;
    assign bus.fifo_half      = half_r;
    assign bus.fifo_empty     = empty_r;
    assign bus.fifo_overflow  = overflow_r;
    assign bus.overflow_count = overflow_count_r;
endmodule
